// File: rtl/vx_tag_access_nway_pkg.sv
// Shared types and geometry helpers for the N-way tag store.
package vx_tag_access_nway_pkg;

  typedef enum logic {INIT, RUN} state_e;

  function automatic int calc_sets(input int cache_size, input int line_size,
                                   input int num_banks, input int num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction

  function automatic int calc_set_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  function automatic int calc_tag_w(input int line_addr_width, input int set_w);
    return line_addr_width - set_w;
  endfunction

  function automatic int calc_ptr_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/vx_tag_access_nway_if.sv
// Request/response bundle between the bank request pipe (master) and the tag store (slave).
interface vx_tag_access_nway_if #(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int NUM_WAYS        = 4
);
  logic                       stall;
  logic                       lookup;
  logic [LINE_ADDR_WIDTH-1:0] addr;
  logic                       fill;
  logic                       flush;
  logic                       is_load;
  logic                       is_mrsq_enable;
  logic                       should_reserve;
  logic                       ready;
  logic                       tag_match;
  logic [NUM_WAYS-1:0]        hit_way;
  logic                       reserved;
  logic [NUM_WAYS-1:0]        victim_way;

  modport master (
    output stall, lookup, addr, fill, flush, is_load, is_mrsq_enable, should_reserve,
    input  ready, tag_match, hit_way, reserved, victim_way
  );

  modport slave (
    input  stall, lookup, addr, fill, flush, is_load, is_mrsq_enable, should_reserve,
    output ready, tag_match, hit_way, reserved, victim_way
  );
endinterface

// File: rtl/vx_tag_access_nway_victim_sel.sv
// Fill victim choice: lowest invalid way, else the round-robin way; advance flags an eviction.
// Purely combinational.
module vx_tag_access_nway_victim_sel #(
  parameter int NUM_WAYS = 4,
  parameter int PTR_W    = 2
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [PTR_W-1:0]    rr_ptr,
  output logic [NUM_WAYS-1:0] victim,
  output logic                advance
);

  if (NUM_WAYS == 1) begin : g_direct
    logic unused_in;
    assign unused_in = ^{valid, rr_ptr};
    assign victim    = 1'b1;
    assign advance   = 1'b0;
  end else begin : g_assoc
    logic found;
    always_comb begin
      victim  = '0;
      found   = 1'b0;
      advance = &valid;
      if (advance) begin
        victim[rr_ptr] = 1'b1;
      end else begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (!valid[w] && !found) begin
            victim[w] = 1'b1;
            found     = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/vx_tag_access_nway.sv
// N-way set-associative tag store for one cache bank with LR/SC reservation bits.
// Reads are combinational from flop arrays; writes land on the next clock unless stalled.
module vx_tag_access_nway
  import vx_tag_access_nway_pkg::*;
#(
  parameter int CACHE_ID        = 0,
  parameter int BANK_ID         = 0,
  parameter int CACHE_SIZE      = 16384,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int NUM_BANKS       = 4,
  parameter int NUM_WAYS        = 4,
  parameter int LINE_ADDR_WIDTH = 26
) (
  input logic                 clk,
  input logic                 reset_n,
  vx_tag_access_nway_if.slave bus
);

  localparam int SETS  = calc_sets(CACHE_SIZE, CACHE_LINE_SIZE, NUM_BANKS, NUM_WAYS);
  localparam int SET_W = calc_set_w(SETS);
  localparam int TAG_W = calc_tag_w(LINE_ADDR_WIDTH, SET_W);
  localparam int PTR_W = calc_ptr_w(NUM_WAYS);
  localparam int CTR_W = SET_W + 1;

  state_e              state_q;
  logic                ready_q;
  logic [CTR_W-1:0]    sweep_ctr_q;
  logic [TAG_W-1:0]    tag_q   [SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [SETS];
  logic [NUM_WAYS-1:0] resv_q  [SETS];
  logic [PTR_W-1:0]    rr_q    [SETS];

  logic [SET_W-1:0]    set_idx, sweep_set;
  logic [TAG_W-1:0]    req_tag;
  logic [NUM_WAYS-1:0] match, victim, wr_way, new_resv;
  logic                any_hit, advance, keep_resv, upd_en;

  logic unused_ids;
  assign unused_ids = ^{CACHE_ID, BANK_ID};

  assign set_idx   = bus.addr[SET_W-1:0];
  assign req_tag   = bus.addr[LINE_ADDR_WIDTH-1:SET_W];
  assign sweep_set = sweep_ctr_q[SET_W-1:0];

  always_comb begin
    match = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag);
    end
  end

  assign any_hit   = |match;
  assign keep_resv = bus.is_load | bus.is_mrsq_enable;
  // A fill that already matches rewrites that way, keeping the one-match invariant.
  assign wr_way    = any_hit ? match : victim;
  assign new_resv  = keep_resv ? resv_q[set_idx] : {NUM_WAYS{bus.should_reserve}};
  assign upd_en    = (state_q == RUN) && !bus.stall;

  vx_tag_access_nway_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .PTR_W    (PTR_W)
  ) u_victim_sel (
    .valid   (valid_q[set_idx]),
    .rr_ptr  (rr_q[set_idx]),
    .victim  (victim),
    .advance (advance)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      sweep_ctr_q <= '0;
      ready_q     <= 1'b0;
    end else if (state_q == INIT) begin
      sweep_ctr_q <= sweep_ctr_q + CTR_W'(1);
      if (sweep_ctr_q == CTR_W'(SETS - 1)) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      valid_q[sweep_set] <= '0;
      resv_q[sweep_set]  <= '0;
    end else if (upd_en) begin
      if (bus.flush) begin
        valid_q[set_idx] <= valid_q[set_idx] & ~match;
        resv_q[set_idx]  <= resv_q[set_idx] & ~match;
      end else if (bus.fill) begin
        valid_q[set_idx] <= valid_q[set_idx] | wr_way;
        resv_q[set_idx]  <= (resv_q[set_idx] & ~wr_way) | (wr_way & new_resv);
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (wr_way[w]) tag_q[set_idx][w] <= req_tag;
        end
      end else if (bus.lookup && any_hit && !keep_resv) begin
        // Store/SC hit overwrites the reservation; loads and replays leave it alone.
        resv_q[set_idx] <= (resv_q[set_idx] & ~match) | (match & {NUM_WAYS{bus.should_reserve}});
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (upd_en && !bus.flush && bus.fill && !any_hit && advance) begin
      rr_q[set_idx] <= rr_q[set_idx] + PTR_W'(1);
    end
  end

  assign bus.ready      = ready_q;
  assign bus.tag_match  = ready_q & any_hit;
  assign bus.hit_way    = ready_q ? match : '0;
  assign bus.reserved   = ready_q & |(match & resv_q[set_idx]);
  assign bus.victim_way = ready_q ? victim : '0;

endmodule

// File: tb/tb_vx_tag_access_nway.sv
// Randomized and directed bench for the 4-way, 16-set tag store against an array-based model.
module tb_vx_tag_access_nway;

  logic clk;
  logic reset_n;

  vx_tag_access_nway_if #(.LINE_ADDR_WIDTH(26), .NUM_WAYS(4)) bus ();

  vx_tag_access_nway dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vecs = 0;
  int errs = 0;

  int unsigned m_tag   [16][4];
  bit          m_valid [16][4];
  bit          m_resv  [16][4];
  int          m_rr    [16];
  bit          m_run;

  bit          e_hit;
  bit          e_rs;
  logic [3:0]  e_hw;
  logic [3:0]  e_vw;

  logic [21:0] tags [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [25:0] mk(input logic [21:0] t, input logic [3:0] s);
    return {t, s};
  endfunction

  task automatic drive(input bit lk, input bit fl, input bit fs, input logic [25:0] a,
                       input bit ld, input bit mq, input bit sr, input bit st);
    bus.lookup         = lk;
    bus.fill           = fl;
    bus.flush          = fs;
    bus.addr           = a;
    bus.is_load        = ld;
    bus.is_mrsq_enable = mq;
    bus.should_reserve = sr;
    bus.stall          = st;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_resv[s][w]  = 0;
        m_tag[s][w]   = 0;
      end
    end
  endtask

  // Expected combinational outputs for the address currently on the bus.
  task automatic model_eval();
    int unsigned s, t;
    s = bus.addr % 16;
    t = bus.addr / 16;
    e_hit = 0; e_rs = 0; e_hw = '0; e_vw = '0;
    if (!m_run) return;
    for (int w = 0; w < 4; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == t) begin
        e_hit = 1;
        e_hw  = 4'(1 << w);
        e_rs  = m_resv[s][w];
      end
    end
    e_vw = 4'(1 << m_rr[s]);
    for (int w = 3; w >= 0; w--) if (!m_valid[s][w]) e_vw = 4'(1 << w);
  endtask

  task automatic model_commit();
    int unsigned s, t;
    int hw, w;
    bit nr;
    if (!m_run || bus.stall) return;
    s  = bus.addr % 16;
    t  = bus.addr / 16;
    hw = -1;
    for (int i = 0; i < 4; i++) if (m_valid[s][i] && m_tag[s][i] == t) hw = i;
    if (bus.flush) begin
      if (hw >= 0) begin
        m_valid[s][hw] = 0;
        m_resv[s][hw]  = 0;
      end
    end else if (bus.fill) begin
      w = hw;
      if (w < 0) for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) begin
        w       = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % 4;
      end
      nr            = (bus.is_load || bus.is_mrsq_enable) ? m_resv[s][w] : bus.should_reserve;
      m_valid[s][w] = 1;
      m_tag[s][w]   = t;
      m_resv[s][w]  = nr;
    end else if (bus.lookup && hw >= 0 && !bus.is_load && !bus.is_mrsq_enable) begin
      m_resv[s][hw] = bus.should_reserve;
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] a;
    m_run   = 0;
    reset_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    vecs++;
    if (bus.ready !== 1'b0 || bus.tag_match !== 1'b0 || bus.victim_way !== 4'b0) begin
      errs++;
      $display("FAIL reset_outputs got ready=%b match=%b victim=%b exp all zero",
               bus.ready, bus.tag_match, bus.victim_way);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    a = mk(22'h12345, 4'd2);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0, a, 0, 0, 1, i[1]);
      @(negedge clk);
      vecs++;
      if (bus.ready !== 1'b0) begin
        errs++;
        $display("FAIL init_ready cycle %0d got=%b exp=0", i, bus.ready);
      end
      vecs++;
      if (bus.tag_match !== 1'b0) begin
        errs++;
        $display("FAIL init_tag_match cycle %0d got=%b exp=0", i, bus.tag_match);
      end
      tick();
    end
    model_clear();
    m_run = 1;
    drive(1, 0, 0, a, 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_after_sweep got=%b exp=1", bus.ready);
    end
    vecs++;
    if (bus.tag_match !== 1'b0) begin
      errs++;
      $display("FAIL init_fill_ignored got=%b exp=0", bus.tag_match);
    end
    tick();
  endtask

  task automatic test_fill_ways();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = 4'(1 << i);
      drive(0, 1, 0, mk(tags[i], 4'd3), 0, 0, 0, 0);
      @(negedge clk);
      vecs++;
      if (bus.victim_way !== exp) begin
        errs++;
        $display("FAIL fill%0d_victim got=%b exp=%b", i, bus.victim_way, exp);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      exp = 4'(1 << i);
      drive(1, 0, 0, mk(tags[i], 4'd3), 1, 0, 0, 0);
      @(negedge clk);
      vecs++;
      if (bus.tag_match !== 1'b1 || bus.hit_way !== exp) begin
        errs++;
        $display("FAIL lookup%0d got match=%b way=%b exp match=1 way=%b",
                 i, bus.tag_match, bus.hit_way, exp);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    drive(0, 1, 0, mk(tags[4], 4'd3), 0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.victim_way !== 4'b0001) begin
      errs++;
      $display("FAIL rr_first_victim got=%b exp=0001", bus.victim_way);
    end
    tick();
    drive(0, 1, 0, mk(tags[5], 4'd3), 0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.victim_way !== 4'b0010) begin
      errs++;
      $display("FAIL rr_second_victim got=%b exp=0010", bus.victim_way);
    end
    tick();
    drive(1, 0, 0, mk(tags[0], 4'd3), 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b0 || bus.hit_way !== 4'b0) begin
      errs++;
      $display("FAIL evicted_A got match=%b way=%b exp 0/0000", bus.tag_match, bus.hit_way);
    end
    tick();
    drive(1, 0, 0, mk(tags[4], 4'd3), 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.hit_way !== 4'b0001) begin
      errs++;
      $display("FAIL lookup_E got=%b exp=0001", bus.hit_way);
    end
    tick();
  endtask

  task automatic test_reservation();
    logic [25:0] g;
    g = mk(tags[9], 4'd5);
    drive(0, 1, 0, g, 1, 0, 1, 0);
    tick();
    drive(1, 0, 0, g, 1, 0, 1, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b1 || bus.reserved !== 1'b0) begin
      errs++;
      $display("FAIL lr_fill_keeps_old got match=%b resv=%b exp 1/0", bus.tag_match, bus.reserved);
    end
    tick();
    drive(0, 1, 0, g, 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, g, 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.reserved !== 1'b1) begin
      errs++;
      $display("FAIL reserve_set got=%b exp=1", bus.reserved);
    end
    tick();
    drive(1, 0, 0, g, 0, 1, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.reserved !== 1'b1) begin
      errs++;
      $display("FAIL load_keeps_resv got=%b exp=1", bus.reserved);
    end
    tick();
    drive(1, 0, 0, g, 0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.reserved !== 1'b1) begin
      errs++;
      $display("FAIL replay_keeps_resv got=%b exp=1", bus.reserved);
    end
    tick();
    drive(1, 0, 0, g, 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.reserved !== 1'b0) begin
      errs++;
      $display("FAIL sw_clears_resv got=%b exp=0", bus.reserved);
    end
    tick();
  endtask

  task automatic test_flush();
    drive(0, 0, 1, mk(tags[5], 4'd3), 0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.hit_way !== 4'b0010) begin
      errs++;
      $display("FAIL flush_old_visible got=%b exp=0010", bus.hit_way);
    end
    tick();
    drive(0, 1, 0, mk(tags[6], 4'd3), 0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b0 || bus.victim_way !== 4'b0010) begin
      errs++;
      $display("FAIL post_flush got match=%b victim=%b exp 0/0010", bus.tag_match, bus.victim_way);
    end
    tick();
    drive(0, 1, 0, mk(tags[7], 4'd3), 0, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.victim_way !== 4'b0100) begin
      errs++;
      $display("FAIL rr_held_on_invalid_fill got=%b exp=0100", bus.victim_way);
    end
    tick();
    drive(0, 1, 1, mk(tags[7], 4'd3), 0, 0, 1, 0);
    tick();
    drive(0, 1, 1, mk(tags[8], 4'd3), 0, 0, 1, 0);
    tick();
    drive(1, 0, 0, mk(tags[7], 4'd3), 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b0 || bus.victim_way !== 4'b0100) begin
      errs++;
      $display("FAIL fill_flush_same got match=%b victim=%b exp 0/0100", bus.tag_match, bus.victim_way);
    end
    tick();
    drive(1, 0, 0, mk(tags[8], 4'd3), 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b0) begin
      errs++;
      $display("FAIL flush_miss_fill_dropped got=%b exp=0", bus.tag_match);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [25:0] g;
    g = mk(tags[9], 4'd5);
    drive(0, 1, 0, g, 0, 0, 1, 0);
    tick();
    drive(0, 1, 0, mk(tags[10], 4'd5), 0, 0, 0, 1);
    tick();
    drive(0, 0, 1, g, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, g, 0, 0, 0, 1);
    tick();
    drive(1, 0, 0, g, 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b1 || bus.hit_way !== 4'b0001 || bus.reserved !== 1'b1) begin
      errs++;
      $display("FAIL stall_hold got match=%b way=%b resv=%b exp 1/0001/1",
               bus.tag_match, bus.hit_way, bus.reserved);
    end
    tick();
    drive(1, 0, 0, mk(tags[10], 4'd5), 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b0 || bus.victim_way !== 4'b0010) begin
      errs++;
      $display("FAIL stall_fill_dropped got match=%b victim=%b exp 0/0010", bus.tag_match, bus.victim_way);
    end
    tick();
  endtask

  task automatic test_random();
    int op;
    logic [3:0] s;
    for (int c = 0; c < 300; c++) begin
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 2))
        0:       s = 4'd1;
        1:       s = 4'd3;
        default: s = 4'd9;
      endcase
      drive(op < 4, op >= 4 && op < 8, op >= 7 && op < 9, mk(tags[$urandom_range(0, 7)], s),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 6) == 0);
      @(negedge clk);
      model_eval();
      vecs++;
      if (bus.tag_match !== e_hit) begin
        errs++;
        $display("FAIL rnd_match cyc %0d got=%b exp=%b", c, bus.tag_match, e_hit);
      end
      vecs++;
      if (bus.hit_way !== e_hw) begin
        errs++;
        $display("FAIL rnd_hit_way cyc %0d got=%b exp=%b", c, bus.hit_way, e_hw);
      end
      vecs++;
      if (bus.reserved !== e_rs) begin
        errs++;
        $display("FAIL rnd_reserved cyc %0d got=%b exp=%b", c, bus.reserved, e_rs);
      end
      vecs++;
      if (bus.victim_way !== e_vw) begin
        errs++;
        $display("FAIL rnd_victim cyc %0d got=%b exp=%b", c, bus.victim_way, e_vw);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [25:0] g;
    g = mk(tags[9], 4'd5);
    drive(1, 0, 0, g, 1, 0, 0, 0);
    @(negedge clk);
    vecs++;
    if (bus.tag_match !== 1'b1) begin
      errs++;
      $display("FAIL pre_reset_hit got=%b exp=1", bus.tag_match);
    end
    tick();
    m_run   = 0;
    reset_n = 1'b0;
    @(negedge clk);
    vecs++;
    if (bus.ready !== 1'b0 || bus.tag_match !== 1'b0 || bus.hit_way !== 4'b0) begin
      errs++;
      $display("FAIL reset_forces_zero got ready=%b match=%b way=%b exp 0/0/0000",
               bus.ready, bus.tag_match, bus.hit_way);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (7) tick();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vecs++;
      if (bus.ready !== 1'b0) begin
        errs++;
        $display("FAIL resweep_ready cycle %0d got=%b exp=0", i, bus.ready);
      end
      tick();
    end
    model_clear();
    m_run = 1;
    @(negedge clk);
    vecs++;
    if (bus.ready !== 1'b1 || bus.tag_match !== 1'b0) begin
      errs++;
      $display("FAIL resweep_done got ready=%b match=%b exp 1/0", bus.ready, bus.tag_match);
    end
    tick();
  endtask

  initial begin
    int unsigned base;
    base = $urandom_range(0, 4000000);
    for (int i = 0; i < 12; i++) tags[i] = 22'(base + i * 3);
    reset_n = 1'b0;
    idle();
    test_reset();
    test_fill_ways();
    test_round_robin();
    test_reservation();
    test_flush();
    test_stall();
    test_random();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
